// File: rtl/pipeline_controller_if.sv
// ---------------------------------------------------------------------------
// pipeline_controller_if
// Bundles the sequencer's request inputs and its stage-control outputs.
//   master : hazard unit / memories / MDU side (drives requests, reads controls)
//   slave  : pipeline_controller (reads requests, drives controls)
// Signals:
//   load_use, flush_req, imem_ready, dmem_req_mem, dmem_ready,
//   mdu_start_ex, mdu_done                 -> requests and handshakes
//   pc_enable, *_enable, *_flush           -> PC / pipeline register control
//   mem_fault                              -> data-memory timeout pulse
//   stall_count, flush_count (CNT_W)       -> performance counters
// ---------------------------------------------------------------------------
interface pipeline_controller_if #(
    parameter int CNT_W = 32
);
    logic             load_use;
    logic             flush_req;
    logic             imem_ready;
    logic             dmem_req_mem;
    logic             dmem_ready;
    logic             mdu_start_ex;
    logic             mdu_done;

    logic             pc_enable;
    logic             if_id_enable;
    logic             id_ex_enable;
    logic             ex_mem_enable;
    logic             mem_wb_enable;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_flush;
    logic             mem_wb_flush;
    logic             mem_fault;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output load_use, flush_req, imem_ready, dmem_req_mem, dmem_ready,
               mdu_start_ex, mdu_done,
        input  pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable,
               if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
               mem_fault, stall_count, flush_count
    );

    modport slave (
        input  load_use, flush_req, imem_ready, dmem_req_mem, dmem_ready,
               mdu_start_ex, mdu_done,
        output pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable,
               if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
               mem_fault, stall_count, flush_count
    );
endinterface

// File: rtl/pipeline_controller.sv
// ---------------------------------------------------------------------------
// pipeline_controller
// Central sequencer for the 5-stage RV32 pipeline. Merges hazard-unit stall
// and flush requests with the instruction/data memory handshakes and the
// multi-cycle MDU, and produces one enable and one bubble per pipeline
// register plus the PC enable. Also keeps stall/flush counters and a
// data-memory timeout watchdog.
// Ports:
//   clk  : core clock
//   rst  : asynchronous active-high reset
//   ctl  : pipeline_controller_if.slave (requests in, stage controls out)
// Parameters:
//   MEM_TIMEOUT : cycles spent in MEM_WAIT before the watchdog fires
//   CNT_W       : performance counter width
// ---------------------------------------------------------------------------
module pipeline_controller #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_controller_if.slave  ctl
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, MDU_WAIT} state_t;

    localparam logic [15:0] WD_LIMIT = 16'(MEM_TIMEOUT);

    state_t      state_reg, state_next;
    logic [15:0] wd_reg, wd_next;
    logic [CNT_W-1:0] stall_count_reg, flush_count_reg;

    // One-hot "which rule won this cycle" flags; outputs are derived from them.
    logic mem_freeze;   // freeze PC..EX/MEM, bubble into MEM/WB
    logic mdu_freeze;   // freeze PC..ID/EX, bubble into EX/MEM
    logic redirect;     // taken branch: squash IF/ID and ID/EX, PC loads target
    logic lu_stall;     // load-use: freeze PC and IF/ID, bubble into ID/EX
    logic fetch_stall;  // fetch not ready: freeze PC, bubble into IF/ID
    logic fault;        // watchdog expiry: squash everything, return to RUN
    logic run_eval;
    logic mem_stall;

    logic pc_en, if_id_en, id_ex_en, ex_mem_en;
    logic if_id_fl, id_ex_fl, ex_mem_fl, mem_wb_fl;

    assign mem_stall = ctl.dmem_req_mem & ~ctl.dmem_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= RUN;
            wd_reg    <= '0;
        end else begin
            state_reg <= state_next;
            wd_reg    <= wd_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        wd_next     = wd_reg;
        mem_freeze  = 1'b0;
        mdu_freeze  = 1'b0;
        redirect    = 1'b0;
        lu_stall    = 1'b0;
        fetch_stall = 1'b0;
        fault       = 1'b0;
        run_eval    = 1'b0;

        case (state_reg)
            RUN: run_eval = 1'b1;
            MEM_WAIT: begin
                if (!ctl.dmem_ready) begin
                    if (wd_reg == WD_LIMIT) begin
                        fault      = 1'b1;
                        state_next = RUN;
                        wd_next    = '0;
                    end else begin
                        mem_freeze = 1'b1;
                        wd_next    = wd_reg + 16'd1;
                    end
                end else begin
                    // Access completes: the rest of the pipeline is evaluated
                    // as in RUN during this same cycle.
                    run_eval = 1'b1;
                end
            end
            MDU_WAIT: begin
                // A MEM-stage stall downstream overrides the MDU hold.
                if (mem_stall) begin
                    mem_freeze = 1'b1;
                end else if (ctl.mdu_done) begin
                    state_next = RUN;
                end else begin
                    mdu_freeze = 1'b1;
                end
            end
            default: state_next = RUN;
        endcase

        if (run_eval) begin
            state_next = RUN;
            wd_next    = '0;
            if (mem_stall) begin
                mem_freeze = 1'b1;
                state_next = MEM_WAIT;
                wd_next    = 16'd1;
            end else if (ctl.mdu_start_ex && !ctl.mdu_done) begin
                mdu_freeze = 1'b1;
                state_next = MDU_WAIT;
            end else if (ctl.flush_req) begin
                redirect = 1'b1;
            end else if (ctl.load_use) begin
                lu_stall = 1'b1;
            end else if (!ctl.imem_ready) begin
                fetch_stall = 1'b1;
            end
        end
    end

    // Each freeze disables its own stage and everything upstream of it.
    assign pc_en     = ~(mem_freeze | mdu_freeze | lu_stall | fetch_stall | fault);
    assign if_id_en  = ~(mem_freeze | mdu_freeze | lu_stall);
    assign id_ex_en  = ~(mem_freeze | mdu_freeze);
    assign ex_mem_en = ~mem_freeze;
    assign if_id_fl  = redirect | fetch_stall | fault;
    assign id_ex_fl  = redirect | lu_stall | fault;
    assign ex_mem_fl = mdu_freeze | fault;
    assign mem_wb_fl = mem_freeze | fault;

    // Controls read 0 throughout reset.
    assign ctl.pc_enable     = pc_en & ~rst;
    assign ctl.if_id_enable  = if_id_en & ~rst;
    assign ctl.id_ex_enable  = id_ex_en & ~rst;
    assign ctl.ex_mem_enable = ex_mem_en & ~rst;
    assign ctl.mem_wb_enable = ~rst;
    assign ctl.if_id_flush   = if_id_fl & ~rst;
    assign ctl.id_ex_flush   = id_ex_fl & ~rst;
    assign ctl.ex_mem_flush  = ex_mem_fl & ~rst;
    assign ctl.mem_wb_flush  = mem_wb_fl & ~rst;
    assign ctl.mem_fault     = fault & ~rst;

    // Counters wrap naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_reg <= '0;
            flush_count_reg <= '0;
        end else begin
            if (!pc_en) begin
                stall_count_reg <= stall_count_reg + 1'b1;
            end
            if (redirect) begin
                flush_count_reg <= flush_count_reg + 1'b1;
            end
        end
    end

    assign ctl.stall_count = stall_count_reg;
    assign ctl.flush_count = flush_count_reg;
endmodule

// File: tb/tb_pipeline_controller.sv
// ---------------------------------------------------------------------------
// tb_pipeline_controller
// Drives directed and random request patterns; a reference model expresses
// each cycle as "freeze everything up to stage k and bubble stage k" (or a
// redirect / fault), pushes the expected controls and counters into a queue,
// and an independent monitor pops and compares at every falling edge.
// ---------------------------------------------------------------------------
module tb_pipeline_controller;
    localparam int CNT_W       = 32;
    localparam int MEM_TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipeline_controller_if #(.CNT_W(CNT_W)) bus ();

    pipeline_controller #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .ctl (bus)
    );

    // ctl vector: {pc, if_id, id_ex, ex_mem, mem_wb enables,
    //              if_id, id_ex, ex_mem, mem_wb flushes, mem_fault}
    typedef struct {
        logic [9:0]       ctl;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc_n = 0;

    // Reference model state
    bit               m_mem_wait = 1'b0;
    bit               m_mdu_wait = 1'b0;
    int               m_wd       = 0;
    logic [CNT_W-1:0] m_sc       = '0;
    logic [CNT_W-1:0] m_fc       = '0;

    function automatic bit rnd(input int pct);
        return $urandom_range(0, 99) < pct;
    endfunction

    // Apply one cycle of inputs and push the expected response.
    task automatic cycle(input bit r, input bit lu, input bit fr, input bit im,
                         input bit dq, input bit dr, input bit ms, input bit md);
        bit [4:0] en;   // [0]=pc .. [4]=mem_wb
        bit [4:1] fl;   // [1]=if_id .. [4]=mem_wb
        bit       flt;
        int       k;    // freeze depth: stages 0..k-1 held, bubble into k
        exp_t     e;
        @(posedge clk);
        #1;
        rst              = r;
        bus.load_use     = lu;
        bus.flush_req    = fr;
        bus.imem_ready   = im;
        bus.dmem_req_mem = dq;
        bus.dmem_ready   = dr;
        bus.mdu_start_ex = ms;
        bus.mdu_done     = md;
        en  = '1;
        fl  = '0;
        flt = 1'b0;
        k   = 0;
        if (r) begin
            m_mem_wait = 1'b0;
            m_mdu_wait = 1'b0;
            m_wd       = 0;
            m_sc       = '0;
            m_fc       = '0;
            e.ctl      = '0;
            e.sc       = '0;
            e.fc       = '0;
        end else begin
            e.sc = m_sc;
            e.fc = m_fc;
            if (m_mem_wait && !dr) begin
                if (m_wd == MEM_TIMEOUT) begin
                    flt        = 1'b1;
                    fl         = '1;
                    en[0]      = 1'b0;
                    m_mem_wait = 1'b0;
                    m_wd       = 0;
                end else begin
                    k    = 4;
                    m_wd = m_wd + 1;
                end
            end else if (m_mdu_wait) begin
                if (dq && !dr)  k = 4;
                else if (md)    m_mdu_wait = 1'b0;
                else            k = 3;
            end else begin
                m_mem_wait = 1'b0;
                m_wd       = 0;
                if (dq && !dr) begin
                    k          = 4;
                    m_mem_wait = 1'b1;
                    m_wd       = 1;
                end else if (ms && !md) begin
                    k          = 3;
                    m_mdu_wait = 1'b1;
                end else if (fr) begin
                    fl[1] = 1'b1;
                    fl[2] = 1'b1;
                    m_fc  = m_fc + 1'b1;
                end else if (lu) begin
                    k = 2;
                end else if (!im) begin
                    k = 1;
                end
            end
            for (int i = 0; i < k; i++) en[i] = 1'b0;
            if (k > 0) fl[k] = 1'b1;
            if (!en[0]) m_sc = m_sc + 1'b1;
            e.ctl = {en[0], en[1], en[2], en[3], en[4], fl[1], fl[2], fl[3], fl[4], flt};
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(0, 0, 0, 1, 0, 1, 0, 0);
    endtask

    // Monitor: compares every cycle for which the driver queued an expectation.
    initial begin
        exp_t       e;
        logic [9:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {bus.pc_enable, bus.if_id_enable, bus.id_ex_enable,
                       bus.ex_mem_enable, bus.mem_wb_enable, bus.if_id_flush,
                       bus.id_ex_flush, bus.ex_mem_flush, bus.mem_wb_flush,
                       bus.mem_fault};
                $display("cyc=%0d rst=%0b ctl=%b stall=%0d flush=%0d",
                         cyc_n, rst, act, bus.stall_count, bus.flush_count);
                total++;
                if (act !== e.ctl) begin
                    bad++;
                    $display("FAIL ctl_vec cyc=%0d actual=%b required=%b", cyc_n, act, e.ctl);
                end
                total++;
                if (bus.stall_count !== e.sc) begin
                    bad++;
                    $display("FAIL stall_count cyc=%0d actual=%0d required=%0d",
                             cyc_n, bus.stall_count, e.sc);
                end
                total++;
                if (bus.flush_count !== e.fc) begin
                    bad++;
                    $display("FAIL flush_count cyc=%0d actual=%0d required=%0d",
                             cyc_n, bus.flush_count, e.fc);
                end
                cyc_n++;
            end
        end
    end

    initial begin
        int pct;
        bus.load_use     = 1'b0;
        bus.flush_req    = 1'b0;
        bus.imem_ready   = 1'b1;
        bus.dmem_req_mem = 1'b0;
        bus.dmem_ready   = 1'b1;
        bus.mdu_start_ex = 1'b0;
        bus.mdu_done     = 1'b0;

        // Reset, then ten quiet cycles
        repeat (2) cycle(1, 0, 0, 1, 0, 1, 0, 0);
        idle(10);
        // Single load-use stall
        cycle(0, 1, 0, 1, 0, 1, 0, 0);
        idle(2);
        // Data memory stalls three cycles, then completes
        repeat (3) cycle(0, 0, 0, 1, 1, 0, 0, 0);
        cycle(0, 0, 0, 1, 1, 1, 0, 0);
        idle(1);
        // Branch flush together with load-use
        cycle(0, 1, 1, 1, 0, 1, 0, 0);
        idle(1);
        // Watchdog timeout: fault on the fifth stalled cycle
        repeat (6) cycle(0, 0, 0, 1, 1, 0, 0, 0);
        idle(2);
        // MDU op with a 2-cycle MEM freeze in the middle of the wait
        cycle(0, 0, 0, 1, 0, 1, 1, 0);
        repeat (2) cycle(0, 0, 0, 1, 0, 1, 0, 0);
        repeat (2) cycle(0, 0, 0, 1, 1, 0, 0, 0);
        repeat (3) cycle(0, 0, 0, 1, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0, 1, 0, 1);
        // Single-cycle MDU op, fetch stall
        cycle(0, 0, 0, 1, 0, 1, 1, 1);
        cycle(0, 0, 0, 0, 0, 1, 0, 0);
        // Reset pulse mid MDU wait, then mid MEM wait
        cycle(0, 0, 0, 1, 0, 1, 1, 0);
        cycle(0, 0, 1, 1, 0, 1, 0, 0);
        cycle(1, 0, 0, 1, 0, 1, 0, 0);
        idle(2);
        repeat (2) cycle(0, 0, 0, 1, 1, 0, 0, 0);
        cycle(1, 0, 0, 1, 1, 0, 0, 0);
        cycle(0, 0, 1, 1, 0, 1, 0, 0);
        idle(1);

        // Random traffic with phases of fast, slow and very slow data memory
        pct = 85;
        for (int n = 0; n < 3000; n++) begin
            if (n % 60 == 0) begin
                case ($urandom_range(0, 2))
                    0:       pct = 85;
                    1:       pct = 40;
                    default: pct = 5;
                endcase
            end
            cycle(($urandom_range(0, 199) == 0), rnd(20), rnd(15), !rnd(15),
                  rnd(30), ($urandom_range(0, 99) < pct), rnd(15), rnd(35));
        end

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain actual=%0d required=0 pending entries", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
